// File: rtl/kernel_run_sequencer.sv
// rtl/kernel_run_sequencer.sv - ap_ctrl_hs run sequencer with AXI-stream stall watchdog
// Optional: define SEQ_CYCLE_COUNT_EN to build the per-invocation cycle counter.
module kernel_run_sequencer #(
   parameter int N_AXIS = 2,
   parameter int RUNS_W = 16,
   parameter int TMO_W  = 20
) (
   input  logic              kernel_monitor_clock,
   input  logic              kernel_monitor_reset,
   input  logic              go,
   input  logic [RUNS_W-1:0] cfg_num_runs,
   input  logic [TMO_W-1:0]  cfg_timeout,
   output logic              ap_start,
   input  logic              ap_ready,
   input  logic              ap_done,
   input  logic              ap_idle,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   output logic              busy,
   output logic [RUNS_W-1:0] runs_done,
   output logic              seq_done,
   output logic              kernel_block,
   output logic [N_AXIS-1:0] stall_mask,
   output logic [31:0]       last_run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_IDLE, S_START, S_RUN, S_FIN, S_STALL
   } state_t;

   state_t            state_q, state_d;
   logic [RUNS_W-1:0] num_runs_q, num_runs_d;
   logic [TMO_W-1:0]  timeout_q, timeout_d;
   logic [TMO_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic [RUNS_W-1:0] runs_done_q, runs_done_d;
   logic [N_AXIS-1:0] stall_mask_q, stall_mask_d;
   logic              ap_start_q, busy_q, seq_done_q, kernel_block_q;
   logic              blocked, watched, run_done, wd_fire;
   logic [RUNS_W-1:0] runs_inc;
   logic [TMO_W-1:0]  wd_inc;

   assign blocked  = |axis_block_sigs;
   assign watched  = (state_q == S_START) || (state_q == S_RUN);
   assign run_done = ((state_q == S_RUN) && ap_done) ||
                     ((state_q == S_START) && ap_ready && ap_done);
   assign runs_inc = (&runs_done_q) ? runs_done_q : runs_done_q + RUNS_W'(1);
   assign wd_inc   = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + TMO_W'(1);

   // A cycle with ap_done never advances the watchdog, so a finishing run always beats a stall.
   assign wd_fire  = watched && (timeout_q != '0) && blocked && !ap_done && (wd_inc == timeout_q);

   // Counter is zero outside START/RUN, which also gives the clear on every START entry.
   always_comb begin
      wd_cnt_d = '0;
      if (watched && blocked && (timeout_q != '0))
         wd_cnt_d = ap_done ? wd_cnt_q : wd_inc;
   end

   always_comb begin
      state_d      = state_q;
      num_runs_d   = num_runs_q;
      timeout_d    = timeout_q;
      runs_done_d  = runs_done_q;
      stall_mask_d = stall_mask_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (cfg_num_runs != '0) begin
                  num_runs_d   = cfg_num_runs;
                  timeout_d    = cfg_timeout;
                  runs_done_d  = '0;
                  stall_mask_d = '0;
                  state_d      = S_WAIT_IDLE;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (ap_idle)
               state_d = S_START;
         end
         S_START, S_RUN: begin
            if (run_done) begin
               runs_done_d = runs_inc;
               state_d     = (runs_inc == num_runs_q) ? S_FIN : S_WAIT_IDLE;
            end else if (wd_fire) begin
               stall_mask_d = axis_block_sigs;
               state_d      = S_STALL;
            end else if ((state_q == S_START) && ap_ready) begin
               state_d = S_RUN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         S_STALL: begin
            if (go)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset) begin
         state_q        <= S_IDLE;
         num_runs_q     <= '0;
         timeout_q      <= '0;
         wd_cnt_q       <= '0;
         runs_done_q    <= '0;
         stall_mask_q   <= '0;
         ap_start_q     <= 1'b0;
         busy_q         <= 1'b0;
         seq_done_q     <= 1'b0;
         kernel_block_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         num_runs_q     <= num_runs_d;
         timeout_q      <= timeout_d;
         wd_cnt_q       <= wd_cnt_d;
         runs_done_q    <= runs_done_d;
         stall_mask_q   <= stall_mask_d;
         ap_start_q     <= (state_d == S_START);
         busy_q         <= (state_d != S_IDLE);
         seq_done_q     <= (state_d == S_FIN);
         kernel_block_q <= (state_d == S_STALL);
      end
   end

   assign ap_start     = ap_start_q;
   assign busy         = busy_q;
   assign runs_done    = runs_done_q;
   assign seq_done     = seq_done_q;
   assign kernel_block = kernel_block_q;
   assign stall_mask   = stall_mask_q;

`ifdef SEQ_CYCLE_COUNT_EN
   logic [31:0] cyc_q, cyc_d, cyc_inc, last_cyc_q, last_cyc_d;

   assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

   // The loaded value includes the ap_done cycle itself.
   always_comb begin
      cyc_d      = watched ? cyc_inc : '0;
      last_cyc_d = run_done ? cyc_inc : last_cyc_q;
   end

   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset) begin
         cyc_q      <= '0;
         last_cyc_q <= '0;
      end else begin
         cyc_q      <= cyc_d;
         last_cyc_q <= last_cyc_d;
      end
   end

   assign last_run_cycles = last_cyc_q;
`else
   assign last_run_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_run_sequencer.sv
// tb/tb_kernel_run_sequencer.sv - randomized self-checking bench for kernel_run_sequencer
module tb_kernel_run_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        go = 1'b0;
   logic [15:0] cfg_num_runs = '0;
   logic [19:0] cfg_timeout = '0;
   logic        ap_start;
   logic        ap_ready = 1'b0;
   logic        ap_done = 1'b0;
   logic        ap_idle = 1'b0;
   logic [1:0]  axis_block_sigs = '0;
   logic        busy;
   logic [15:0] runs_done;
   logic        seq_done;
   logic        kernel_block;
   logic [1:0]  stall_mask;
   logic [31:0] last_run_cycles;

   int n_checks = 0;
   int n_pass = 0;
   bit blk_rand = 1'b0;

   kernel_run_sequencer #(.N_AXIS(2), .RUNS_W(16), .TMO_W(20)) dut (
      .kernel_monitor_clock (clk),
      .kernel_monitor_reset (rst),
      .go                   (go),
      .cfg_num_runs         (cfg_num_runs),
      .cfg_timeout          (cfg_timeout),
      .ap_start             (ap_start),
      .ap_ready             (ap_ready),
      .ap_done              (ap_done),
      .ap_idle              (ap_idle),
      .axis_block_sigs      (axis_block_sigs),
      .busy                 (busy),
      .runs_done            (runs_done),
      .seq_done             (seq_done),
      .kernel_block         (kernel_block),
      .stall_mask           (stall_mask),
      .last_run_cycles      (last_run_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Expected last_run_cycles for an invocation spanning 'span' cycles from START to ap_done.
   function automatic logic [31:0] exp_lrc(input int span);
`ifdef SEQ_CYCLE_COUNT_EN
      return 32'(span);
`else
      return 32'd0 & 32'(span);
`endif
   endfunction

   task automatic step();
      if (blk_rand) axis_block_sigs = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic go_pulse(input int num, input int tmo);
      go = 1'b1;
      cfg_num_runs = 16'(num);
      cfg_timeout = 20'(tmo);
      step();
      go = 1'b0;
   endtask

   // Kernel model: idle after a random delay, ready rdy cycles after start, done dn cycles after ready.
   task automatic run_normal(input int num, input int tmo, input int rdy_fix, input int dn_fix);
      int idle_lat, rdy_lat, done_lat;
      go_pulse(num, tmo);
      check_val("busy_after_go", busy, 1);
      check_val("runs_cleared", runs_done, 0);
      for (int r = 0; r < num; r++) begin
         idle_lat = $urandom_range(0, 2);
         rdy_lat  = (rdy_fix < 0) ? $urandom_range(0, 2) : rdy_fix;
         done_lat = (dn_fix < 0) ? $urandom_range(0, 5) : dn_fix;
         for (int i = 0; i < idle_lat; i++) begin
            ap_idle = 1'b0;
            step();
            check_val("start_before_idle", ap_start, 0);
         end
         ap_idle = 1'b1;
         step();
         check_val("start_rise", ap_start, 1);
         for (int i = 0; i < rdy_lat; i++) begin
            step();
            check_val("start_held", ap_start, 1);
         end
         ap_ready = 1'b1;
         ap_idle = 1'b0;
         if (done_lat == 0) ap_done = 1'b1;
         step();
         ap_ready = 1'b0;
         ap_done = 1'b0;
         check_val("start_drop", ap_start, 0);
         if (done_lat > 0) begin
            for (int i = 1; i < done_lat; i++) step();
            ap_done = 1'b1;
            step();
            ap_done = 1'b0;
         end
         check_val("runs_done", runs_done, r + 1);
         check_val("last_run_cycles", last_run_cycles, exp_lrc(rdy_lat + done_lat + 1));
         if (r == num - 1) begin
            check_val("seq_done_pulse", seq_done, 1);
            ap_idle = 1'b1;
            step();
            check_val("busy_fall", busy, 0);
            check_val("seq_done_single", seq_done, 0);
         end else begin
            check_val("seq_done_early", seq_done, 0);
            check_val("busy_between", busy, 1);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      step();
      step();
      check_val("rst_busy", busy, 0);
      check_val("rst_ap_start", ap_start, 0);
      check_val("rst_runs_done", runs_done, 0);
      check_val("rst_seq_done", seq_done, 0);
      check_val("rst_kernel_block", kernel_block, 0);
      check_val("rst_stall_mask", stall_mask, 0);
      check_val("rst_last_run_cycles", last_run_cycles, 0);
      rst = 1'b0;
      step();

      run_normal(3, 0, 1, 5);

      blk_rand = 1'b1;
      for (int s = 0; s < 6; s++)
         run_normal($urandom_range(1, 4), ($urandom_range(0, 1) == 1) ? 1000 : 0, -1, -1);
      blk_rand = 1'b0;
      axis_block_sigs = '0;

      go_pulse(0, 0);
      check_val("zero_seq_done", seq_done, 1);
      check_val("zero_ap_start", ap_start, 0);
      step();
      check_val("zero_seq_done_single", seq_done, 0);
      check_val("zero_busy_fall", busy, 0);
      check_val("zero_ap_start_after", ap_start, 0);

      go_pulse(2, 8);
      ap_idle = 1'b1;
      step();
      ap_ready = 1'b1;
      ap_idle = 1'b0;
      step();
      ap_ready = 1'b0;
      axis_block_sigs = 2'b10;
      repeat (7) step();
      check_val("wd_not_yet", kernel_block, 0);
      step();
      check_val("wd_fire", kernel_block, 1);
      check_val("wd_stall_mask", stall_mask, 2'b10);
      check_val("wd_ap_start", ap_start, 0);
      check_val("wd_busy", busy, 1);
      axis_block_sigs = 2'b01;
      repeat (3) step();
      check_val("wd_mask_frozen", stall_mask, 2'b10);
      check_val("wd_block_held", kernel_block, 1);
      axis_block_sigs = 2'b00;
      go_pulse(3, 0);
      check_val("wd_cleared", kernel_block, 0);
      check_val("wd_rearm_idle", busy, 0);
      step();
      check_val("wd_rearm_no_start", ap_start, 0);

      go_pulse(1, 6);
      ap_idle = 1'b1;
      step();
      ap_ready = 1'b1;
      ap_idle = 1'b0;
      step();
      ap_ready = 1'b0;
      axis_block_sigs = 2'b01;
      repeat (5) step();
      ap_done = 1'b1;
      step();
      ap_done = 1'b0;
      axis_block_sigs = 2'b00;
      check_val("race_no_stall", kernel_block, 0);
      check_val("race_runs_done", runs_done, 1);
      check_val("race_seq_done", seq_done, 1);
      step();
      check_val("race_busy_fall", busy, 0);

      go_pulse(3, 0);
      ap_idle = 1'b1;
      step();
      ap_ready = 1'b1;
      ap_done = 1'b1;
      step();
      ap_ready = 1'b0;
      ap_done = 1'b0;
      check_val("start_done_counts", runs_done, 1);
      step();
      ap_ready = 1'b1;
      step();
      ap_ready = 1'b0;
      ap_idle = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_ap_start", ap_start, 0);
      check_val("mid_rst_runs_done", runs_done, 0);
      check_val("mid_rst_seq_done", seq_done, 0);
      check_val("mid_rst_kernel_block", kernel_block, 0);
      check_val("mid_rst_last_run_cycles", last_run_cycles, 0);
      ap_done = 1'b1;
      ap_idle = 1'b1;
      step();
      ap_done = 1'b0;
      check_val("post_rst_ignore_done", runs_done, 0);
      check_val("post_rst_idle", busy, 0);
      run_normal(2, 0, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kernel_run_sequencer.md
# kernel_run_sequencer

Sequences repeated invocations of an HLS kernel through its ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_idle). It sits beside the kernel in the simulation top, next to the deadlock monitor. A stall watchdog watches the kernel's AXI-stream block signals and aborts the run sequence when a stream stays blocked for longer than a programmable limit.

## Interface
- N_AXIS, 2: number of AXI-stream block signals watched.
- RUNS_W, 16: width of the run count.
- TMO_W, 20: width of the watchdog limit and counter.

- kernel_monitor_clock  in  1  sole clock; all logic on rising edge.
- kernel_monitor_reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle start (or re-arm) pulse.
- cfg_num_runs  in  RUNS_W  number of kernel invocations; sampled on accepted go.
- cfg_timeout  in  TMO_W  watchdog limit in cycles; 0 disables watchdog; sampled on accepted go.
- ap_start  out  1  kernel start request.
- ap_ready  in  1  kernel accepted start.
- ap_done  in  1  kernel finished one invocation.
- ap_idle  in  1  kernel idle.
- axis_block_sigs  in  N_AXIS  bit i = 1: stream i is blocked this cycle.
- busy  out  1  sequence in progress (any state other than IDLE).
- runs_done  out  RUNS_W  completed invocations in the current or last sequence.
- seq_done  out  1  one-cycle pulse when all runs have completed.
- kernel_block  out  1  watchdog fired; held until re-armed.
- stall_mask  out  N_AXIS  axis_block_sigs captured in the cycle the watchdog fired.
- last_run_cycles  out  32  cycle count of the last completed invocation (see Configuration).

## Operation
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- IDLE:
  - go with cfg_num_runs ≠ 0: latch the config, clear runs_done and stall_mask, go to WAIT_IDLE.
  - go with cfg_num_runs = 0: go to FIN without any kernel invocation.
- WAIT_IDLE: stay until ap_idle = 1, then go to START.
- START: ap_start = 1. Stay until ap_ready = 1, then go to RUN.
  - If ap_done is also 1 in that cycle, the run is counted immediately, as if in RUN.
- RUN: ap_start = 0. On ap_done = 1, increment runs_done.
  - If the new count equals the latched run count, go to FIN.
  - Otherwise go to WAIT_IDLE.
- FIN: seq_done = 1 for exactly one cycle, then IDLE.
- STALL: ap_start = 0, kernel_block = 1, stall_mask frozen. Leave only on go, which returns to IDLE and clears kernel_block; it does not start a new sequence.
- go is ignored in WAIT_IDLE, START, RUN and FIN.
- Watchdog:
  - Active in START and RUN when the latched timeout ≠ 0.
  - The counter increments each cycle in which |axis_block_sigs = 1 and ap_done = 0.
  - The counter clears to 0 in any cycle with all block bits 0, and on every entry to START.
  - When the counter reaches the latched timeout, go to STALL and capture stall_mask.
  - The counter saturates and does not wrap.
- Simultaneous ap_done and watchdog expiry in the same cycle: ap_done wins; the run counts and no stall occurs.
- runs_done saturates at all-ones; it never wraps.
- Reset mid-sequence: immediate return to IDLE, all outputs 0, kernel outputs ignored thereafter.

## Timing
- go in cycle n → busy = 1 in cycle n+1 (WAIT_IDLE).
- If ap_idle = 1 in n+1 → ap_start = 1 in n+2.
- ap_start drops the cycle after ap_ready is sampled high.
- ap_done sampled in cycle m → runs_done updated in m+1.
- On the final ap_done in cycle m: seq_done is pulsed in m+1; busy = 0 in m+2.
- Blocked from cycle k with timeout T → kernel_block = 1 in cycle k+T.
- Minimum spacing between invocations: 3 cycles (RUN → WAIT_IDLE → START).

## Configuration
- SEQ_CYCLE_COUNT_EN defined:
  - A 32-bit counter clears on entry to START and increments every cycle in START/RUN.
  - On ap_done, its value plus 1 is loaded into last_run_cycles.
  - The counter saturates.
- SEQ_CYCLE_COUNT_EN undefined: counter not built; last_run_cycles is tied to 0. Port list is unchanged.

## Test plan
- Runs: cfg_num_runs = 3, timeout = 0; kernel model ready 1 cycle after start, done 5 cycles later → three ap_start pulses; runs_done goes 1, 2, 3; one seq_done; busy low 2 cycles after the third ap_done.
- Zero runs: go with cfg_num_runs = 0 → seq_done pulse in cycle n+1; ap_start never asserted.
- Watchdog: timeout = 8, axis_block_sigs = 2'b10 held during RUN → kernel_block = 1 exactly 8 cycles after the block begins; stall_mask = 2'b10; ap_start = 0; go clears kernel_block.
- Watchdog race: block held so expiry lands in the same cycle as ap_done → runs_done increments; kernel_block stays 0.
- Reset: kernel_monitor_reset asserted in RUN for 1 cycle → all outputs 0 the next cycle; go afterwards starts cleanly with runs_done = 0.
- With SEQ_CYCLE_COUNT_EN: ready and done as in the first scenario (start through done spans 7 cycles) → last_run_cycles = 7 after each run; without the macro → last_run_cycles = 0.
